alu_commit_stage: RTL

//  Consumer side of the ALU output interface: accepts result/enable_pc_write/valid per ALU op,

---
 rtl/alu_commit_stage_pkg.sv | 31 +++
 rtl/alu_commit_stage_fifo.sv | 75 +++++++
 rtl/alu_commit_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_commit_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_commit_stage_pkg
// Brief   : Shared types and helpers for the ALU commit stage.
// Revision: 1.0 - initial release
// ============================================================================
package alu_commit_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_BEQ, OP_BNE, OP_BLT, OP_BLTU, OP_BGE, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } alu_operation_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
    } commit_entry_t;

    typedef logic [0:0] commit_state_t;
    localparam commit_state_t ST_RUN   = 1'b0;
    localparam commit_state_t ST_FLUSH = 1'b1;

    function automatic logic is_cond_branch(input alu_operation_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BLTU, OP_BGE, OP_BGEU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_commit_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module  : alu_commit_stage_fifo
// Brief   : In-order writeback FIFO; head is always visible on head_o.
// Revision: 1.0 - initial release
// ============================================================================
module alu_commit_stage_fifo
    import alu_commit_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  commit_entry_t wdata_i,
    output commit_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    commit_entry_t    mem_q [DEPTH];
    commit_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_commit_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_commit_stage
// Brief   : ALU commit: writeback FIFO, registered PC redirect, flush window.
// Revision: 1.0 - initial release
// ============================================================================
module alu_commit_stage
    import alu_commit_stage_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  alu_operation_t  operation_i,
    input  logic [XLEN-1:0] result_i,
    input  logic            enable_pc_write_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [4:0]      dest_reg_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_reg_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_addr_o,
    output logic            flush_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    commit_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_addr_q, redirect_addr_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            accept;
    logic            push;
    commit_entry_t   push_entry;
    commit_entry_t   head;

    assign pop        = ~fifo_empty & wb_ready_i;
    assign ready_o    = (state_q == ST_RUN) & (~fifo_full | pop);
    assign accept     = valid_i & ready_o;
    assign push       = accept & ~is_cond_branch(operation_i) & (dest_reg_i != 5'd0);
    assign push_entry = '{data: result_i, rd: dest_reg_i};

    alu_commit_stage_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wb_valid_o = ~fifo_empty;
    assign wb_data_o  = head.data;
    assign wb_reg_o   = head.rd;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_addr_d  = redirect_addr_q;
        case (state_q)
            ST_RUN: begin
                if (accept && enable_pc_write_i) begin
                    redirect_valid_d = 1'b1;
                    redirect_addr_d  = branch_target_i;
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            default: begin
                // Flush window lasts exactly FLUSH_CYCLES cycles from the pulse.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_addr_q  <= redirect_addr_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign flush_o          = (state_q == ST_FLUSH);

endmodule
`default_nettype wire
